pc_npc_unit: RTL

PC_NPC_UNIT -- requirements
Module: pc_npc_unit

---
 rtl/pc_npc_unit_pkg.sv | 37 +++
 rtl/npc_sel.sv | 71 +++++++
 rtl/pc_npc_unit.sv | 88 ++++++++
 3 files changed

// File: rtl/pc_npc_unit_pkg.sv
// ============================================================================
// Module  : pc_npc_unit_pkg
// Brief   : Shared next-PC operation codes, selection enum and helpers
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_npc_unit_pkg;

    // Width of the next-PC operation field
    localparam int NPC_W = 4;

    // Next-PC operation codes; any code not listed here fetches sequentially
    localparam logic [NPC_W-1:0] NPC_SEQ    = 4'd0;
    localparam logic [NPC_W-1:0] NPC_BRANCH = 4'd1;
    localparam logic [NPC_W-1:0] NPC_J      = 4'd2;
    localparam logic [NPC_W-1:0] NPC_JR     = 4'd3;

    // Fetch PC loaded by reset
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

    // Resolved target source after condition evaluation
    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_J      = 2'd2,
        SEL_JR     = 2'd3
    } npc_sel_e;

    // Sign-extend a 16-bit word offset and convert it to a byte offset
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/npc_sel.sv
// ============================================================================
// Module  : npc_sel
// Brief   : Combinational next-PC target selection (SEQ/BRANCH/J/JR)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module npc_sel
    import pc_npc_unit_pkg::*;
(
    input  logic [31:0]      F_pc,
    input  logic [NPC_W-1:0] D_NPCop,
    input  logic [31:0]      D_pc,
    input  logic [15:0]      D_imm16,
    input  logic [25:0]      D_imm26,
    input  logic [31:0]      D_rs_data,
    input  logic             cmp_true,
    output logic [31:0]      next_pc,
    output logic             redirect
);

    npc_sel_e    sel;
    logic [31:0] seq_target;
    logic [31:0] d_pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    // Candidate targets; all arithmetic wraps modulo 2^32
    assign seq_target    = F_pc + 32'd4;
    assign d_pc_plus4    = D_pc + 32'd4;
    assign branch_target = d_pc_plus4 + branch_offset(D_imm16);
    assign jump_target   = {d_pc_plus4[31:28], D_imm26, 2'b00};

    // Decode the operation; a branch with a false condition falls back to SEQ
    always_comb begin
        sel = SEL_SEQ;
        case (D_NPCop)
            NPC_BRANCH: sel = cmp_true ? SEL_BRANCH : SEL_SEQ;
            NPC_J:      sel = SEL_J;
            NPC_JR:     sel = SEL_JR;
            default:    sel = SEL_SEQ;
        endcase
    end

    // Target mux; jr passes the register value through unaligned on purpose
    always_comb begin
        next_pc  = seq_target;
        redirect = 1'b0;
        case (sel)
            SEL_BRANCH: begin
                next_pc  = branch_target;
                redirect = 1'b1;
            end
            SEL_J: begin
                next_pc  = jump_target;
                redirect = 1'b1;
            end
            SEL_JR: begin
                next_pc  = D_rs_data;
                redirect = 1'b1;
            end
            default: begin
                next_pc  = seq_target;
                redirect = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pc_npc_unit.sv
// ============================================================================
// Module  : pc_npc_unit
// Brief   : Fetch PC register with next-PC selection, redirect flag,
//           sticky misalignment flag and saturating redirect counter
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_npc_unit
    import pc_npc_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             F_en,
    input  logic [NPC_W-1:0] D_NPCop,
    input  logic [31:0]      D_pc,
    input  logic [15:0]      D_imm16,
    input  logic [25:0]      D_imm26,
    input  logic [31:0]      D_rs_data,
    input  logic [31:0]      D_CMP_result,
    output logic [31:0]      F_pc,
    output logic             F_redirect,
    output logic             F_misalign,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [31:0]      D_link_addr
);

    logic [31:0] next_pc;
    logic        redirect;
    logic        cmp_true;
    logic        cnt_full;

    // Only bit 0 of the comparator carries the condition; the upper bits are
    // folded in under a constant-zero mask so they never affect the result
    assign cmp_true = D_CMP_result[0] | (1'b0 & (|D_CMP_result[31:1]));

    // Link value for jal/jalr-style instructions: skip the delay slot
    assign D_link_addr = D_pc + 32'd8;

    assign cnt_full = &taken_cnt;

    npc_sel u_npc_sel (
        .F_pc      (F_pc),
        .D_NPCop   (D_NPCop),
        .D_pc      (D_pc),
        .D_imm16   (D_imm16),
        .D_imm26   (D_imm26),
        .D_rs_data (D_rs_data),
        .cmp_true  (cmp_true),
        .next_pc   (next_pc),
        .redirect  (redirect)
    );

    // Fetch PC and redirect flag; a stall holds both and drops the decision
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            F_pc       <= PC_RESET;
            F_redirect <= 1'b0;
        end else if (F_en) begin
            F_pc       <= next_pc;
            F_redirect <= redirect;
        end
    end

    // Sticky flag for any accepted next PC that is not word aligned
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            F_misalign <= 1'b0;
        end else if (F_en && (next_pc[1:0] != 2'b00)) begin
            F_misalign <= 1'b1;
        end
    end

    // Accepted-redirect counter, saturating at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taken_cnt <= '0;
        end else if (F_en && redirect && !cnt_full) begin
            taken_cnt <= taken_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire
